count_sequencer: RTL and testbench

//  Run-control sequencer for the 4-bit free-running counter datapath: owns the counter register and

---
 rtl/count_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_count_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
// Run-control sequencer for a free-running counter. Owns the count register and
// steps it through load / run / pause / terminal-count under a start/ack
// handshake. Supports one-shot and periodic (auto-reload) runs with a
// programmable period and a tick prescaler of DIV run cycles per count step.
//
// Parameters
//   WIDTH   counter and period width in bits
//   DIV     run cycles per counter advance (>= 1)
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous active-low reset
//   start   in   1      run request, sampled in IDLE only
//   period  in   WIDTH  ticks per run, latched on accepted start
//   mode    in   1      0 one-shot, 1 periodic, latched on accepted start
//   pause   in   1      level, freezes counting in RUN/HOLD
//   stop    in   1      aborts the run, highest priority in RUN/HOLD
//   ack     in   1      clears done, sampled in DONE only
//   count   out  WIDTH  current count
//   busy    out  1      high in LOAD, RUN, HOLD
//   done    out  1      high in DONE until ack
//   tc      out  1      one-cycle terminal-count pulse
//   err     out  1      one-cycle pulse on start with period == 0
// -----------------------------------------------------------------------------
module count_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  input  logic             pause,
  input  logic             stop,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err
);

  // Prescaler needs at least one bit even when DIV == 1 (always ticks).
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q,   mode_d;
  logic [PW-1:0]    pre_q,    pre_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             tc_q,     tc_d;
  logic             err_q,    err_d;

  logic             tick;
  logic [WIDTH-1:0] term_cnt;
  logic             at_term;

  assign tick     = (pre_q == PRE_LAST);
  assign term_cnt = period_q - WIDTH'(1);
  assign at_term  = (count_q == term_cnt);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (period == '0) begin
            err_d = 1'b1;
          end else begin
            period_d = period;
            mode_d   = mode;
            state_d  = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        count_d = '0;
        pre_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (stop) begin
          // Abort wins over a coincident terminal tick: no tc.
          count_d = '0;
          pre_d   = '0;
          state_d = S_IDLE;
        end else if (pause) begin
          // Pause wins over a coincident tick; prescaler phase is kept.
          state_d = S_HOLD;
        end else if (tick) begin
          pre_d = '0;
          if (at_term) begin
            tc_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

      S_HOLD: begin
        if (stop) begin
          count_d = '0;
          pre_d   = '0;
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags follow the state being entered so they line up with it.
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      pre_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tc    = tc_q;
  assign err   = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// -----------------------------------------------------------------------------
// tb_count_sequencer
// Directed scenarios followed by random traffic on two instances (DIV=1 and
// DIV=3) sharing one set of inputs. Expected outputs come from a run-progress
// model: each run is described by the number of ticks taken so far, and count,
// tc and done are derived from that with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_count_sequencer;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] period;
  logic             mode;
  logic             pause;
  logic             stop;
  logic             ack;

  logic [WIDTH-1:0] count1, count3;
  logic             busy1, busy3, done1, done3, tc1, tc3, err1, err3;

  int checks = 0;
  int errors = 0;

  count_sequencer #(.WIDTH(WIDTH), .DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .start(start), .period(period), .mode(mode),
    .pause(pause), .stop(stop), .ack(ack),
    .count(count1), .busy(busy1), .done(done1), .tc(tc1), .err(err1)
  );

  count_sequencer #(.WIDTH(WIDTH), .DIV(3)) u_div3 (
    .clk(clk), .reset(reset), .start(start), .period(period), .mode(mode),
    .pause(pause), .stop(stop), .ack(ack),
    .count(count3), .busy(busy3), .done(done3), .tc(tc3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-progress model of one sequencer.
  typedef struct {
    bit active;   // a run is in progress (load, counting or paused)
    bit load;     // first cycle of an accepted run
    bit hold;     // counting suspended by pause
    bit done;
    bit mode;
    bit tc;
    bit err;
    int p;        // latched period
    int ticks;    // ticks taken in this run
    int pre;      // run cycles since the last tick
    int cnt;      // visible count
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.active = 0; n.load = 0; n.hold = 0; n.done = 0; n.mode = 0;
    n.tc = 0; n.err = 0; n.p = 0; n.ticks = 0; n.pre = 0; n.cnt = 0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int div, input bit st,
                                    input int per, input bit md, input bit pa,
                                    input bit sp, input bit ak);
    mdl_t n = s;
    n.tc  = 0;
    n.err = 0;
    if (s.done) begin
      if (ak) n.done = 0;
    end else if (!s.active) begin
      if (st) begin
        if (per == 0) n.err = 1;
        else begin
          n.active = 1; n.load = 1; n.p = per; n.mode = md;
        end
      end
    end else if (s.load) begin
      n.load = 0; n.ticks = 0; n.pre = 0; n.cnt = 0;
    end else if (sp) begin
      n.active = 0; n.hold = 0; n.cnt = 0; n.pre = 0;
    end else if (s.hold) begin
      if (!pa) n.hold = 0;
    end else if (pa) begin
      n.hold = 1;
    end else if (s.pre == div - 1) begin
      n.pre   = 0;
      n.ticks = s.ticks + 1;
      if (n.ticks % s.p == 0) n.tc = 1;
      if (s.mode) begin
        n.cnt = n.ticks % s.p;
      end else if (n.ticks >= s.p) begin
        n.cnt = s.p - 1; n.active = 0; n.done = 1;
      end else begin
        n.cnt = n.ticks;
      end
    end else begin
      n.pre = s.pre + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("d1_count", 32'(count1), m1.cnt);
    chk("d1_busy",  32'(busy1),  int'(m1.active));
    chk("d1_done",  32'(done1),  int'(m1.done));
    chk("d1_tc",    32'(tc1),    int'(m1.tc));
    chk("d1_err",   32'(err1),   int'(m1.err));
    chk("d3_count", 32'(count3), m3.cnt);
    chk("d3_busy",  32'(busy3),  int'(m3.active));
    chk("d3_done",  32'(done3),  int'(m3.done));
    chk("d3_tc",    32'(tc3),    int'(m3.tc));
    chk("d3_err",   32'(err3),   int'(m3.err));
  endtask

  // One clock edge: advance the models with the inputs present at the edge,
  // then sample the DUTs 1ns later.
  task automatic cycle();
    @(posedge clk);
    if (!reset) begin
      m1 = mdl_reset();
      m3 = mdl_reset();
    end else begin
      m1 = mdl_step(m1, 1, start, int'(period), mode, pause, stop, ack);
      m3 = mdl_step(m3, 3, start, int'(period), mode, pause, stop, ack);
    end
    #1;
    compare_all();
  endtask

  // Return both instances to IDLE, acknowledging any completed run.
  task automatic drain();
    start = 0; pause = 0; stop = 1; ack = 1;
    for (int i = 0; i < 40 && (m1.active || m1.done || m3.active || m3.done); i++)
      cycle();
    stop = 0; ack = 0;
    chk("drain_busy1", 32'(busy1 | done1), 0);
    chk("drain_busy3", 32'(busy3 | done3), 0);
  endtask

  int tc_seen;

  initial begin
    m1 = mdl_reset();
    m3 = mdl_reset();
    start = 1; period = 4'd5; mode = 0; pause = 0; stop = 0; ack = 0;
    reset = 0;

    // T1: reset held with start high.
    repeat (3) begin
      cycle();
      chk("t1_busy", 32'(busy1), 0);
    end
    start = 0;
    reset = 1;
    cycle();
    chk("t1_idle_count", 32'(count1), 0);

    // T2: one-shot, period 4, DIV 1 latency and handshake.
    period = 4'd4; mode = 0; start = 1;
    cycle(); start = 0;
    chk("t2_busy", 32'(busy1), 1);
    cycle(); chk("t2_count0", 32'(count1), 0);
    cycle(); chk("t2_count1", 32'(count1), 1);
    cycle(); chk("t2_count2", 32'(count1), 2);
    cycle(); chk("t2_count3", 32'(count1), 3);
    cycle();
    chk("t2_done", 32'(done1), 1);
    chk("t2_tc",   32'(tc1),   1);
    chk("t2_hold", 32'(count1), 3);
    chk("t2_busy_off", 32'(busy1), 0);
    cycle();
    chk("t2_tc_pulse", 32'(tc1), 0);
    chk("t2_done_kept", 32'(done1), 1);
    ack = 1;
    cycle(); ack = 0;
    chk("t2_ack", 32'(done1), 0);
    drain();

    // T3: periodic, period 15, 40 ticks.
    period = 4'd15; mode = 1; start = 1;
    cycle(); start = 0;
    cycle();
    tc_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (tc1) tc_seen++;
      chk("t3_busy", 32'(busy1), 1);
    end
    chk("t3_tc_count", 32'(tc_seen), 2);
    chk("t3_count", 32'(count1), 10);
    drain();

    // T4: DIV 3, period 4, pause for 5 cycles at count 2.
    period = 4'd4; mode = 0; start = 1;
    cycle(); start = 0;
    for (int i = 0; i < 40 && !(m3.active && !m3.load && m3.cnt == 2); i++)
      cycle();
    chk("t4_reach2", 32'(count3), 2);
    pause = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_frozen", 32'(count3), 2);
    end
    pause = 0;
    for (int i = 0; i < 40 && !m3.done; i++)
      cycle();
    chk("t4_done", 32'(done3), 1);
    chk("t4_final", 32'(count3), 3);
    drain();

    // T5: stop on the terminal tick, then a zero-period start.
    period = 4'd3; mode = 0; start = 1;
    cycle(); start = 0;
    cycle(); cycle(); cycle();
    chk("t5_at_term", 32'(count1), 2);
    stop = 1;
    cycle(); stop = 0;
    chk("t5_count", 32'(count1), 0);
    chk("t5_tc",    32'(tc1),    0);
    chk("t5_done",  32'(done1),  0);
    chk("t5_busy",  32'(busy1),  0);
    drain();
    period = 4'd0; start = 1;
    cycle(); start = 0;
    chk("t5_err", 32'(err1), 1);
    chk("t5_err_busy", 32'(busy1), 0);
    cycle();
    chk("t5_err_pulse", 32'(err1), 0);

    // T6: asynchronous reset mid-run at count 9.
    period = 4'd12; mode = 0; start = 1;
    cycle(); start = 0;
    for (int i = 0; i < 30 && !(m1.active && !m1.load && m1.cnt == 9); i++)
      cycle();
    chk("t6_reach9", 32'(count1), 9);
    #2 reset = 0;
    #1;
    m1 = mdl_reset();
    m3 = mdl_reset();
    compare_all();
    chk("t6_async_count", 32'(count1), 0);
    cycle();
    reset = 1;
    period = 4'd5; start = 1;
    cycle(); start = 0;
    cycle();
    chk("t6_restart0", 32'(count1), 0);
    chk("t6_restart_busy", 32'(busy1), 1);
    cycle();
    chk("t6_restart1", 32'(count1), 1);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom % 5) == 0;
      period = 4'($urandom_range(0, 15));
      mode   = 1'($urandom % 2);
      pause  = ($urandom % 8) == 0;
      stop   = ($urandom % 30) == 0;
      ack    = ($urandom % 4) == 0;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
